// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: control bundle,
// RV32I load/store funct3 encodings and the MEM/WB boundary record.
package memory_stage_pkg;

  typedef struct packed {
    logic MemRead;
    logic MemWrite;
    logic RegWrite;
    logic MemtoReg;
  } control_type;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef struct packed {
    control_type control;
    logic [31:0] alu_data;
    logic [31:0] load_data;
    logic [4:0]  rd;
    logic        valid;
  } mem_wb_type;

  // Sign- or zero-extend a byte or halfword load result to 32 bits.
  function automatic logic [31:0] extend_load(input logic [15:0] v, input logic is_half,
                                              input logic is_unsigned);
    logic [31:0] r;
    if (is_half) r = {{16{v[15] & ~is_unsigned}}, v};
    else         r = {{24{v[7] & ~is_unsigned}}, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-MEM inputs and MEM/WB outputs of the memory stage.
interface memory_stage_if
  import memory_stage_pkg::*;
();
  logic        stall;
  logic        flush;
  logic        valid_in;
  control_type control_in;
  logic [2:0]  funct3;
  logic [31:0] alu_data;
  logic [31:0] memory_data;
  logic [4:0]  rd_in;
  control_type control_out;
  logic [31:0] alu_data_out;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        valid_out;
  logic        misaligned;

  modport master (
    output stall, flush, valid_in, control_in, funct3, alu_data, memory_data, rd_in,
    input  control_out, alu_data_out, load_data, rd_out, valid_out, misaligned
  );

  modport slave (
    input  stall, flush, valid_in, control_in, funct3, alu_data, memory_data, rd_in,
    output control_out, alu_data_out, load_data, rd_out, valid_out, misaligned
  );
endinterface

// File: rtl/memory_stage_data_memory.sv
// Byte-enable data RAM with a registered read port; maps onto block RAM.
module data_memory #(
  parameter int    DMEM_WORDS = 1024,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic [$clog2(DMEM_WORDS)-1:0] i_addr,
  input  logic [3:0]                    i_we,
  input  logic [31:0]                   i_wdata,
  input  logic                          i_re,
  output logic [31:0]                   o_rdata
);
  logic [31:0] r_mem [DMEM_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/memory_stage.sv
// MEM stage: access-fault decode, store lane steering, data memory access,
// MEM/WB output registers and load extraction.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int    DMEM_WORDS = 1024,
  parameter string INIT_FILE  = ""
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);
  localparam int AW = $clog2(DMEM_WORDS);

  logic                w_act, w_fault, w_misalign, w_load_ok, w_store_ok;
  logic                w_wr, w_rd;
  logic [1:0]          w_size;
  logic [3:0]          w_be, w_we;
  logic [31:0]         w_wdata, w_rdata, w_ext;
  logic [AW-1:0]       w_index;
  control_type         w_ctrl_next;
  mem_wb_type          w_mem_wb;

  control_type         r_ctrl;
  logic [31:0]         r_alu;
  logic [4:0]          r_rd;
  logic                r_valid, r_mis, r_load_seen;
  logic [1:0]          r_addr_lo;
  logic [2:0]          r_f3;

  assign w_size     = bus.funct3[1:0];
  assign w_index    = bus.alu_data[AW+1:2];
  assign w_load_ok  = bus.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  assign w_store_ok = bus.funct3 inside {F3_SB, F3_SH, F3_SW};
  assign w_misalign = ((w_size == 2'b01) && bus.alu_data[0]) ||
                      ((w_size == 2'b10) && (bus.alu_data[1:0] != 2'b00));
  assign w_fault    = (bus.control_in.MemRead || bus.control_in.MemWrite) &&
                      (w_misalign || (bus.control_in.MemRead && !w_load_ok) ||
                       (bus.control_in.MemWrite && !w_store_ok));
  assign w_act      = bus.valid_in && !bus.flush && !bus.stall;
  // Reset in the same cycle must suppress any memory side effect.
  assign w_wr       = w_act && bus.control_in.MemWrite && !w_fault && !rst;
  assign w_rd       = w_act && bus.control_in.MemRead && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_be[gi] = (w_size == 2'b00) ? (bus.alu_data[1:0] == 2'(gi)) :
                        (w_size == 2'b01) ? (bus.alu_data[1] == 1'(gi / 2)) : 1'b1;
    end
  endgenerate

  assign w_we = w_wr ? w_be : 4'b0000;

  always_comb begin
    w_wdata = bus.memory_data;
    case (w_size)
      2'b00:   w_wdata = {4{bus.memory_data[7:0]}};
      2'b01:   w_wdata = {2{bus.memory_data[15:0]}};
      default: w_wdata = bus.memory_data;
    endcase
  end

  data_memory #(
    .DMEM_WORDS(DMEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_dmem (
    .clk    (clk),
    .i_addr (w_index),
    .i_we   (w_we),
    .i_wdata(w_wdata),
    .i_re   (w_rd),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_ctrl_next          = bus.control_in;
    w_ctrl_next.RegWrite = bus.control_in.RegWrite && !w_fault;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_alu       <= '0;
      r_rd        <= '0;
      r_mis       <= 1'b0;
      r_load_seen <= 1'b0;
      r_addr_lo   <= '0;
      r_f3        <= '0;
    end else if (!bus.stall) begin
      r_alu <= bus.alu_data;
      r_rd  <= bus.rd_in;
      if (bus.valid_in && !bus.flush) begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl_next;
        r_mis   <= w_fault;
      end else begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_mis   <= 1'b0;
      end
      // Extract selectors only follow loads so load_data holds across non-loads.
      if (w_rd) begin
        r_load_seen <= 1'b1;
        r_addr_lo   <= bus.alu_data[1:0];
        r_f3        <= bus.funct3;
      end
    end
  end

  always_comb begin
    w_ext = w_rdata;
    case (r_f3)
      F3_LB, F3_LBU: w_ext = extend_load({8'h00, w_rdata[{r_addr_lo, 3'b000} +: 8]}, 1'b0, r_f3[2]);
      F3_LH, F3_LHU: w_ext = extend_load(r_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0], 1'b1, r_f3[2]);
      default:       w_ext = w_rdata;
    endcase
  end

  assign w_mem_wb = '{control: r_ctrl, alu_data: r_alu,
                      load_data: (r_load_seen ? w_ext : 32'h0), rd: r_rd, valid: r_valid};

  assign bus.control_out  = w_mem_wb.control;
  assign bus.alu_data_out = w_mem_wb.alu_data;
  assign bus.load_data    = w_mem_wb.load_data;
  assign bus.rd_out       = w_mem_wb.rd;
  assign bus.valid_out    = w_mem_wb.valid;
  assign bus.misaligned   = r_mis;
endmodule

// File: tb/tb_memory_stage.sv
// Randomised and directed bench for memory_stage against a byte-array reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int DMEM_WORDS = 1024;
  localparam int NBYTES     = DMEM_WORDS * 4;
  localparam logic [3:0] LD  = 4'b1011;
  localparam logic [3:0] ST  = 4'b0100;
  localparam logic [3:0] ALU = 4'b0010;

  typedef struct {
    bit          rst;
    bit          valid;
    control_type ctrl;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    bit          stall;
    bit          flush;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_stage_if bus();

  memory_stage #(.DMEM_WORDS(DMEM_WORDS), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0]  ref_mem [NBYTES];
  int          n_checks = 0;
  int          n_errors = 0;
  int          txn_no   = 0;
  bit          exp_valid, exp_mis, exp_data_chk, exp_load_known;
  control_type exp_ctrl;
  logic [31:0] exp_alu, exp_load;
  logic [4:0]  exp_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h (txn %0d)", tag, got, exp, txn_no);
    end
  endtask

  // Reference: byte-addressed memory, access size = 2**funct3[1:0] bytes.
  task automatic model(input txn_t t);
    int          size, base;
    bit          legal, fault;
    logic [31:0] val;
    if (t.rst) begin
      exp_valid = 0; exp_mis = 0; exp_ctrl = '0; exp_alu = '0; exp_rd = '0;
      exp_data_chk = 1; exp_load = '0; exp_load_known = 1;
      return;
    end
    if (t.stall) return;
    if (!t.valid || t.flush) begin
      exp_valid = 0; exp_mis = 0; exp_ctrl = '0; exp_data_chk = 0;
      return;
    end
    size  = 1 << t.f3[1:0];
    base  = int'(t.addr & (NBYTES - 1));
    legal = 1;
    if (t.ctrl.MemRead)  legal = legal && (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (t.ctrl.MemWrite) legal = legal && (t.f3 inside {3'd0, 3'd1, 3'd2});
    fault = (t.ctrl.MemRead || t.ctrl.MemWrite) && (!legal || (base % size) != 0);
    exp_valid = 1; exp_mis = fault; exp_ctrl = t.ctrl;
    if (fault) exp_ctrl.RegWrite = 1'b0;
    exp_alu = t.addr; exp_rd = t.rd; exp_data_chk = 1;
    if (t.ctrl.MemWrite && !fault)
      for (int k = 0; k < size; k++) ref_mem[base + k] = t.data[8*k +: 8];
    if (t.ctrl.MemRead) begin
      if (fault) exp_load_known = 0;
      else begin
        val = '0;
        for (int k = 0; k < size; k++) val[8*k +: 8] = ref_mem[base + k];
        if (!t.f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
        exp_load = val; exp_load_known = 1;
      end
    end
  endtask

  function automatic txn_t mk(input logic [3:0] c, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.rst = 0; t.valid = 1; t.ctrl = control_type'(c); t.f3 = f3;
    t.addr = a; t.data = d; t.rd = 5'($urandom); t.stall = 0; t.flush = 0;
    return t;
  endfunction

  task automatic step(input txn_t t);
    rst             = t.rst;
    bus.valid_in    = t.valid;
    bus.control_in  = t.ctrl;
    bus.funct3      = t.f3;
    bus.alu_data    = t.addr;
    bus.memory_data = t.data;
    bus.rd_in       = t.rd;
    bus.stall       = t.stall;
    bus.flush       = t.flush;
    model(t);
    @(posedge clk);
    #1;
    txn_no++;
    $display("txn %0d rst=%0b v=%0b ctl=%04b f3=%0d addr=%08h data=%08h st=%0b fl=%0b -> v=%0b mis=%0b ctl=%04b ld=%08h",
             txn_no, t.rst, t.valid, t.ctrl, t.f3, t.addr, t.data, t.stall, t.flush,
             bus.valid_out, bus.misaligned, bus.control_out, bus.load_data);
    check_eq("valid_out", {31'b0, bus.valid_out}, {31'b0, exp_valid});
    check_eq("misaligned", {31'b0, bus.misaligned}, {31'b0, exp_mis});
    check_eq("control_out", {28'b0, bus.control_out}, {28'b0, exp_ctrl});
    if (exp_data_chk) begin
      check_eq("alu_data_out", bus.alu_data_out, exp_alu);
      check_eq("rd_out", {27'b0, bus.rd_out}, {27'b0, exp_rd});
    end
    if (exp_load_known) check_eq("load_data", bus.load_data, exp_load);
    @(negedge clk);
  endtask

  initial begin
    txn_t        t;
    logic [3:0]  c;
    logic [2:0]  f3;
    logic [31:0] a, sz;
    int          k;
    rst = 1'b1;
    bus.valid_in = 0; bus.control_in = '0; bus.funct3 = '0; bus.alu_data = '0;
    bus.memory_data = '0; bus.rd_in = '0; bus.stall = 0; bus.flush = 0;
    @(negedge clk);

    t = mk(ST, F3_SW, 32'h0, 32'h0); t.rst = 1;
    step(t); step(t);
    check_eq("rst_load_data", bus.load_data, 32'h0);

    for (int w = 0; w < 256; w++) step(mk(ST, F3_SW, 32'(w * 4), $urandom));

    step(mk(ST, F3_SW, 32'h10, 32'hDEADBEEF));
    step(mk(LD, F3_LW, 32'h10, 32'h0));
    check_eq("t1_lw", bus.load_data, 32'hDEADBEEF);
    check_eq("t1_regwrite", {31'b0, bus.control_out.RegWrite}, 32'd1);

    step(mk(ST, F3_SB, 32'h21, 32'h00000080));
    step(mk(LD, F3_LB, 32'h21, 32'h0));
    check_eq("t2_lb", bus.load_data, 32'hFFFFFF80);
    step(mk(LD, F3_LBU, 32'h21, 32'h0));
    check_eq("t2_lbu", bus.load_data, 32'h00000080);
    step(mk(LD, F3_LW, 32'h20, 32'h0));

    step(mk(ST, F3_SH, 32'h32, 32'h00001234));
    step(mk(LD, F3_LH, 32'h32, 32'h0));
    check_eq("t3_lh", bus.load_data, 32'h00001234);
    step(mk(LD, F3_LW, 32'h30, 32'h0));
    check_eq("t3_lw_upper", {16'h0, bus.load_data[31:16]}, 32'h00001234);

    step(mk(ST, F3_SW, 32'h13, 32'h55555555));
    check_eq("t4_sw_mis", {31'b0, bus.misaligned}, 32'd1);
    check_eq("t4_sw_regwrite", {31'b0, bus.control_out.RegWrite}, 32'd0);
    t = mk(ALU, F3_LB, 32'h0, 32'h0); t.valid = 0;
    step(t);
    check_eq("t4_mis_one_cycle", {31'b0, bus.misaligned}, 32'd0);
    step(mk(LD, F3_LW, 32'h10, 32'h0));
    check_eq("t4_lw_unchanged", bus.load_data, 32'hDEADBEEF);
    step(mk(LD, F3_LH, 32'h11, 32'h0));
    check_eq("t4_lh_mis", {31'b0, bus.misaligned}, 32'd1);

    t = mk(ST, F3_SW, 32'h40, 32'hCAFEF00D); t.stall = 1;
    step(t); step(t); step(t);
    check_eq("t5_stall_frozen", {31'b0, bus.misaligned}, 32'd1);
    t.stall = 0;
    step(t);
    step(mk(LD, F3_LW, 32'h40, 32'h0));
    check_eq("t5_after_stall", bus.load_data, 32'hCAFEF00D);
    t = mk(ST, F3_SW, 32'h44, 32'h11111111); t.flush = 1;
    step(t);
    check_eq("t5_flush_valid", {31'b0, bus.valid_out}, 32'd0);
    step(mk(LD, F3_LW, 32'h44, 32'h0));

    t = mk(ST, F3_SW, 32'h48, 32'h22222222); t.rst = 1;
    step(t);
    check_eq("t6_rst_valid", {31'b0, bus.valid_out}, 32'd0);
    step(mk(LD, F3_LW, 32'h48, 32'h0));
    step(mk(ST, F3_SW, 32'h1010, 32'h5A5A5A5A));
    step(mk(LD, F3_LW, 32'h10, 32'h0));
    check_eq("t6_alias", bus.load_data, 32'h5A5A5A5A);

    for (int i = 0; i < 500; i++) begin
      k = int'($urandom % 4);
      c = (k == 1) ? ST : (k == 2) ? ALU : LD;
      if ($urandom % 5 == 0)  f3 = 3'($urandom % 8);
      else if (k == 1)        f3 = 3'($urandom % 3);
      else begin
        k  = int'($urandom % 5);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end
      sz = 32'd1 << f3[1:0];
      a  = $urandom % 1024;
      if ($urandom % 4 != 0) a = a & ~(sz - 1);
      if ($urandom % 8 == 0) a = a | ($urandom & 32'hFFFFF000);
      t = mk(c, f3, a, $urandom);
      t.valid = ($urandom % 6 != 0);
      t.stall = ($urandom % 6 == 0);
      t.flush = ($urandom % 8 == 0);
      t.rst   = ($urandom % 60 == 0);
      step(t);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
